regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
Write-port controller for the in-order core's 2-read/1-write register file. Arbitrates two writeback sources (port 0 = ALU, port 1 = load unit) onto the single regfile write port with round-robin priority. Holds a per-register busy scoreboard that is set at issue and cleared at write commit. Drives an issue stall on RAW/WAW hazards. Sits between issue/writeback and the regfile's w_en/rd_addr/w_data inputs.

Parameters:
WIDTH, 32, data width of a register
NREG, 32, number of architectural registers; register 0 is hard-wired zero
AW, 5, register address width, equal to clog2(NREG)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
iss_valid  in  1  issue stage presents an instruction that writes iss_rd
iss_ra  in  AW  source A register
iss_rb  in  AW  source B register
iss_rd  in  AW  destination register
iss_stall  out  1  hazard; the instruction must not issue this cycle
wb0_valid  in  1  ALU writeback request
wb0_rd  in  AW  ALU destination register
wb0_data  in  WIDTH  ALU result
wb0_ready  out  1  ALU request granted this cycle
wb1_valid  in  1  load writeback request
wb1_rd  in  AW  load destination register
wb1_data  in  WIDTH  load data
wb1_ready  out  1  load request granted this cycle
rf_w_en  out  1  regfile write enable
rf_rd_addr  out  AW  regfile write address
rf_w_data  out  WIDTH  regfile write data
busy  out  NREG  scoreboard vector
sb_err  out  1  sticky flag: a writeback targeted a register that was not busy

Behaviour:
- Reset (rst low, asynchronous): rf_w_en=0, rf_rd_addr=0, rf_w_data=0, busy=0, sb_err=0, last_grant=1, so port 0 wins the first contested cycle. Any pending output write is dropped.
- Arbitration (combinational):
  - Only one wbN_valid high: grant that port.
  - Both high: grant the port that is not last_grant.
  - Neither high: no grant.
  - wbN_ready = grant_N. A transfer occurs on valid & ready.
  - last_grant updates only on a transfer.
  - A requester must hold valid, rd and data stable until it is granted.
- Write pipe, latency 1: on a transfer at edge T, rf_w_en=1 and rf_rd_addr/rf_w_data are loaded from the granted port during cycle T..T+1. With no transfer, rf_w_en=0 and addr/data hold their previous values.
  - Throughput: one write per cycle.
  - The output never backpressures arbitration.
- Register 0:
  - A writeback with rd=0 is granted, but rf_w_en stays 0 and sb_err is unaffected.
  - busy[0] is constant 0.
  - An issue with iss_rd=0 sets no busy bit.
- Scoreboard:
  - Set: busy[iss_rd] <= 1 at an edge where iss_valid & ~iss_stall & iss_rd!=0.
  - Clear: busy[rf_rd_addr] <= 0 at an edge where rf_w_en=1. The regfile captures the data at that same edge, so readers see the new value from the next cycle.
  - Set and clear of the same index in one cycle cannot happen, because the WAW stall blocks it. If it does occur, set wins.
- Stall (combinational): iss_stall = iss_valid & (busy[iss_ra] | busy[iss_rb] | busy[iss_rd]). There is no forwarding. An operand is usable on the cycle after its busy bit clears.
- sb_err: set when a transfer with rd!=0 finds busy[rd]=0 at that moment. It is cleared only by reset. The write still proceeds.
- Simultaneous events:
  - Issue reserving reg X and a writeback commit to reg Y≠X in the same cycle: both take effect.
  - A granted writeback to X while X is busy and rf_w_en is also clearing X from a previous write: the clear happens, and this transfer sets sb_err only if the busy bit sampled at the transfer edge is 0.

Decomposition:
- Package regfile_pkg:
  - WIDTH, NREG and AW localparams
  - typedef rf_addr_t = logic [AW-1:0]
  - typedef rf_data_t = logic [WIDTH-1:0]
  - packed struct wb_req_t {valid, rd, data}
  - enum port_id_t {WB_ALU=0, WB_MEM=1}
- Sub-module rr_arb2: two-requester round-robin arbiter holding the last_grant flop, with inputs req[1:0] and output gnt[1:0]. The scoreboard and write pipe stay in regfile_wb_ctrl.

Test Plan:
- Reset: hold rst=0, all inputs active -> all outputs 0, busy=0, iss_stall=0. Release rst -> first contested cycle grants wb0.
- Basic: issue rd=5 -> busy[5]=1. Next cycle issue ra=5 -> iss_stall=1. wb0 rd=5 data=0x1234 -> wb0_ready=1; next cycle rf_w_en=1, addr=5, data=0x1234; busy[5]=0 after that edge; stall drops.
- Contention: wb0 and wb1 both valid for 4 cycles with distinct rd 1..4 -> grants alternate 0,1,0,1, one rf write per cycle, no request lost.
- Register 0: wb1 rd=0 data=400 -> wb1_ready=1, rf_w_en stays 0. Issue rd=0 -> busy unchanged, no stall.
- WAW: busy[31]=1, issue rd=31 -> iss_stall=1 until the write to 31 commits.
- Errors and mid-op reset: wb0 rd=7 with busy[7]=0 -> write happens and sb_err=1 sticky. Assert rst while rf_w_en=1 -> rf_w_en=0 immediately, busy and sb_err cleared.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizing for the register-file writeback controller.
// Widths here set the regfile geometry for every file that imports this package.
package regfile_pkg;

  localparam int WIDTH = 32;
  localparam int NREG  = 32;
  localparam int AW    = $clog2(NREG);

  typedef logic [AW-1:0]    rf_addr_t;
  typedef logic [WIDTH-1:0] rf_data_t;

  typedef struct packed {
    logic     valid;
    rf_addr_t rd;
    rf_data_t data;
  } wb_req_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } port_id_t;

  // One-hot decode of a register index into a scoreboard-wide vector.
  function automatic logic [NREG-1:0] reg_onehot(input rf_addr_t a);
    logic [NREG-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; the port not granted last wins a tie.
// Grants are combinational, the history flop advances only on a grant.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_id_t last_grant_q;
  port_id_t last_grant_d;

  always_comb begin
    gnt          = req;
    last_grant_d = last_grant_q;
    if (req == 2'b11) begin
      gnt = (last_grant_q == WB_MEM) ? 2'b01 : 2'b10;
    end
    // gnt is only ever a subset of req, so any grant is a transfer
    if (gnt[1]) begin
      last_grant_d = WB_MEM;
    end else if (gnt[0]) begin
      last_grant_d = WB_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= WB_MEM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Regfile write-port controller: arbitrates ALU/load writebacks, registers the
// single write, tracks per-register busy bits and raises the issue hazard stall.
module regfile_wb_ctrl
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_ra,
  input  logic [AW-1:0]    iss_rb,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_stall,
  input  logic             wb0_valid,
  input  logic [AW-1:0]    wb0_rd,
  input  logic [WIDTH-1:0] wb0_data,
  output logic             wb0_ready,
  input  logic             wb1_valid,
  input  logic [AW-1:0]    wb1_rd,
  input  logic [WIDTH-1:0] wb1_data,
  output logic             wb1_ready,
  output logic             rf_w_en,
  output logic [AW-1:0]    rf_rd_addr,
  output logic [WIDTH-1:0] rf_w_data,
  output logic [NREG-1:0]  busy,
  output logic             sb_err
);

  logic [1:0] gnt;
  wb_req_t    req0;
  wb_req_t    req1;
  wb_req_t    sel;
  logic       transfer;
  logic       iss_accept;

  logic            rf_w_en_q,    rf_w_en_d;
  rf_addr_t        rf_rd_addr_q, rf_rd_addr_d;
  rf_data_t        rf_w_data_q,  rf_w_data_d;
  logic [NREG-1:0] busy_q,       busy_d;
  logic            sb_err_q,     sb_err_d;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  assign req0 = {wb0_valid, wb0_rd, wb0_data};
  assign req1 = {wb1_valid, wb1_rd, wb1_data};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({wb1_valid, wb0_valid}),
    .gnt (gnt)
  );

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];

  // No forwarding: any pending writer of a source or destination blocks issue.
  assign iss_stall  = iss_valid & (busy_q[iss_ra] | busy_q[iss_rb] | busy_q[iss_rd]);
  assign iss_accept = iss_valid & ~iss_stall & (iss_rd != '0);

  always_comb begin
    sel          = gnt[1] ? req1 : req0;
    transfer     = (|gnt) & sel.valid;
    rf_w_en_d    = transfer && (sel.rd != '0);
    rf_rd_addr_d = transfer ? sel.rd : rf_rd_addr_q;
    rf_w_data_d  = transfer ? sel.data : rf_w_data_q;
    // busy_q is sampled before this edge's clear, so a commit landing now does not mask the check
    sb_err_d     = sb_err_q | (transfer && (sel.rd != '0) && !busy_q[sel.rd]);
  end

  always_comb begin
    set_vec = iss_accept ? reg_onehot(iss_rd) : '0;
    clr_vec = rf_w_en_q ? reg_onehot(rf_rd_addr_q) : '0;
    // Set is applied after clear so a same-index collision leaves the bit set
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_w_en_q    <= 1'b0;
      rf_rd_addr_q <= '0;
      rf_w_data_q  <= '0;
      busy_q       <= '0;
      sb_err_q     <= 1'b0;
    end else begin
      rf_w_en_q    <= rf_w_en_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      rf_w_data_q  <= rf_w_data_d;
      busy_q       <= busy_d;
      sb_err_q     <= sb_err_d;
    end
  end

  assign rf_w_en    = rf_w_en_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign rf_w_data  = rf_w_data_q;
  assign busy       = busy_q;
  assign sb_err     = sb_err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: expected regfile writes go into a queue
// that a negedge monitor drains whenever rf_w_en is seen high.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_ra = '0, iss_rb = '0, iss_rd = '0;
  logic        iss_stall;
  logic        wb0_valid = 1'b0;
  logic [4:0]  wb0_rd = '0;
  logic [31:0] wb0_data = '0;
  logic        wb0_ready;
  logic        wb1_valid = 1'b0;
  logic [4:0]  wb1_rd = '0;
  logic [31:0] wb1_data = '0;
  logic        wb1_ready;
  logic        rf_w_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_w_data;
  logic [31:0] busy;
  logic        sb_err;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ra(iss_ra), .iss_rb(iss_rb), .iss_rd(iss_rd),
    .iss_stall(iss_stall),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rf_w_en(rf_w_en), .rf_rd_addr(rf_rd_addr), .rf_w_data(rf_w_data),
    .busy(busy), .sb_err(sb_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Scoreboard monitor: every observed regfile write must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && rf_w_en) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rf_write: unexpected write addr=%0d data=0x%0h", rf_rd_addr, rf_w_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_rd_addr, rf_w_data} !== e) begin
          n_err++;
          $display("FAIL rf_write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h",
                   rf_rd_addr, rf_w_data, e[36:32], e[31:0]);
        end else begin
          $display("ok   rf_write: addr=%0d data=0x%0h", rf_rd_addr, rf_w_data);
        end
      end
    end
  end

  initial begin
    // Reset with every input active
    #1 rst = 1'b0;
    iss_valid = 1; iss_ra = 1; iss_rb = 2; iss_rd = 3;
    wb0_valid = 1; wb0_rd = 1; wb0_data = 32'h11;
    wb1_valid = 1; wb1_rd = 2; wb1_data = 32'h22;
    step(); step();
    check("rst_w_en", {31'd0, rf_w_en}, 32'd0);
    check("rst_addr", {27'd0, rf_rd_addr}, 32'd0);
    check("rst_data", rf_w_data, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_sb_err", {31'd0, sb_err}, 32'd0);
    check("rst_stall", {31'd0, iss_stall}, 32'd0);
    iss_valid = 0; wb0_valid = 0; wb1_valid = 0;
    iss_ra = 0; iss_rb = 0; iss_rd = 0;
    rst = 1'b1;
    step();

    // Reserve r1..r4, then contend
    for (int k = 1; k <= 4; k++) begin
      iss_valid = 1; iss_rd = 5'(k);
      #1 check("iss_stall_free", {31'd0, iss_stall}, 32'd0);
      step();
    end
    iss_valid = 0; iss_rd = 0;
    #1 check("busy_r1_r4", busy, 32'h0000_001E);
    wb0_valid = 1; wb0_rd = 1; wb0_data = 32'hA1;
    wb1_valid = 1; wb1_rd = 2; wb1_data = 32'hB2;
    #1 check("c0_wb0_ready", {30'd0, wb1_ready, wb0_ready}, 32'b01);
    push(1, 32'hA1);
    step();
    wb0_rd = 3; wb0_data = 32'hA3;
    #1 check("c1_wb1_ready", {30'd0, wb1_ready, wb0_ready}, 32'b10);
    push(2, 32'hB2);
    step();
    wb1_rd = 4; wb1_data = 32'hB4;
    #1 check("c2_wb0_ready", {30'd0, wb1_ready, wb0_ready}, 32'b01);
    push(3, 32'hA3);
    step();
    wb0_valid = 0;
    #1 check("c3_wb1_ready", {30'd0, wb1_ready, wb0_ready}, 32'b10);
    push(4, 32'hB4);
    step();
    wb1_valid = 0;
    step(); step();
    check("contend_busy_clear", busy, 32'd0);
    check("contend_sb_err", {31'd0, sb_err}, 32'd0);

    // Basic RAW hazard and commit
    iss_valid = 1; iss_rd = 5;
    step();
    iss_ra = 5; iss_rd = 6;
    wb0_valid = 1; wb0_rd = 5; wb0_data = 32'h1234;
    #1 check("raw_busy5", busy, 32'h0000_0020);
    check("raw_stall", {31'd0, iss_stall}, 32'd1);
    check("raw_wb0_ready", {31'd0, wb0_ready}, 32'd1);
    push(5, 32'h1234);
    step();
    wb0_valid = 0;
    #1 check("raw_w_en", {31'd0, rf_w_en}, 32'd1);
    check("raw_addr", {27'd0, rf_rd_addr}, 32'd5);
    check("raw_data", rf_w_data, 32'h1234);
    check("raw_stall_pending", {31'd0, iss_stall}, 32'd1);
    step();
    #1 check("raw_busy_cleared", busy, 32'd0);
    check("raw_stall_drop", {31'd0, iss_stall}, 32'd0);
    check("raw_w_en_idle", {31'd0, rf_w_en}, 32'd0);
    check("raw_addr_hold", {27'd0, rf_rd_addr}, 32'd5);
    check("raw_data_hold", rf_w_data, 32'h1234);
    step();
    iss_valid = 0; iss_ra = 0; iss_rd = 0;
    #1 check("raw_busy6", busy, 32'h0000_0040);
    wb1_valid = 1; wb1_rd = 6; wb1_data = 32'h66;
    #1 check("raw_wb1_ready", {31'd0, wb1_ready}, 32'd1);
    push(6, 32'h66);
    step();
    wb1_valid = 0;
    step();
    check("raw_busy_empty", busy, 32'd0);

    // Register 0
    wb1_valid = 1; wb1_rd = 0; wb1_data = 32'd400;
    #1 check("r0_wb1_ready", {31'd0, wb1_ready}, 32'd1);
    step();
    wb1_valid = 0;
    #1 check("r0_no_w_en", {31'd0, rf_w_en}, 32'd0);
    iss_valid = 1; iss_rd = 0;
    #1 check("r0_no_stall", {31'd0, iss_stall}, 32'd0);
    step();
    iss_valid = 0;
    #1 check("r0_busy", busy, 32'd0);
    check("r0_sb_err", {31'd0, sb_err}, 32'd0);

    // WAW on r31
    iss_valid = 1; iss_rd = 31;
    step();
    #1 check("waw_busy31", busy, 32'h8000_0000);
    check("waw_stall", {31'd0, iss_stall}, 32'd1);
    step();
    wb0_valid = 1; wb0_rd = 31; wb0_data = 32'hDEAD;
    #1 check("waw_stall_held", {31'd0, iss_stall}, 32'd1);
    check("waw_wb0_ready", {31'd0, wb0_ready}, 32'd1);
    push(31, 32'hDEAD);
    step();
    wb0_valid = 0;
    #1 check("waw_stall_commit", {31'd0, iss_stall}, 32'd1);
    step();
    #1 check("waw_stall_release", {31'd0, iss_stall}, 32'd0);
    step();
    iss_valid = 0; iss_rd = 0;
    #1 check("waw_reissued", busy, 32'h8000_0000);
    wb1_valid = 1; wb1_rd = 31; wb1_data = 32'hBEEF;
    push(31, 32'hBEEF);
    step();
    wb1_valid = 0;
    step();
    check("waw_busy_empty", busy, 32'd0);

    // sb_err and mid-operation reset
    wb0_valid = 1; wb0_rd = 7; wb0_data = 32'h77;
    push(7, 32'h77);
    step();
    wb0_valid = 0;
    #1 check("err_set", {31'd0, sb_err}, 32'd1);
    step();
    check("err_sticky", {31'd0, sb_err}, 32'd1);
    wb1_valid = 1; wb1_rd = 8; wb1_data = 32'h88;
    iss_valid = 1; iss_rd = 9;
    push(8, 32'h88);
    step();
    wb1_valid = 0; iss_valid = 0; iss_rd = 0;
    check("mid_w_en", {31'd0, rf_w_en}, 32'd1);
    check("mid_busy9", busy, 32'h0000_0200);
    rst = 1'b0;
    #1 check("mid_rst_w_en", {31'd0, rf_w_en}, 32'd0);
    check("mid_rst_busy", busy, 32'd0);
    check("mid_rst_sb_err", {31'd0, sb_err}, 32'd0);
    check("mid_rst_addr", {27'd0, rf_rd_addr}, 32'd0);
    exp_q.delete();
    step();
    rst = 1'b1;
    step(); step();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
